prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction fetch path. It receives a framed byte stream over a valid/ready handshake and packs the bytes into 32-bit words. Each word is written into the instruction memory write port, and the CPU is held in reset until the whole image has landed and its checksum has passed. On success the loader releases the CPU and goes inert until the next reset.

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader. It receives a framed byte stream, packs the
// payload into big-endian 32-bit words, and writes each word into the
// instruction memory. The CPU stays in reset until the image has landed
// and its XOR checksum has matched.
module prog_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;

  localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic                rx_ready_q, rx_ready_d;
  logic [15:0]         n_q, n_d;
  logic [7:0]          xor_q, xor_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic                imem_wen_q, imem_wen_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;

  logic                accept;
  logic [15:0]         n_full;
  logic                last_word;

  assign accept    = rx_valid && rx_ready_q;
  assign n_full    = {n_q[15:8], rx_data};
  assign last_word = (32'(words_loaded_q) + 32'd1) == 32'(n_q);

  // Next-state, datapath and write-port computation for one accepted byte
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    xor_d          = xor_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    word_idx_d     = word_idx_q;
    imem_wen_d     = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = words_loaded_q;

    case (state_q)
      HDR0: begin
        if (accept) begin
          n_d[15:8] = rx_data;
          xor_d     = xor_q ^ rx_data;
          state_d   = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          n_d   = n_full;
          xor_d = xor_q ^ rx_data;
          if (32'(n_full) > CAPACITY) begin
            state_d = ERR;
          end else if (n_full == 16'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ rx_data;
          asm_d      = {asm_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_wen_d     = 1'b1;
            imem_addr_d    = word_idx_q;
            imem_wdata_d   = {asm_q, rx_data};
            word_idx_d     = word_idx_q + ADDR_W'(1);
            words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
            if (last_word) begin
              state_d = CHK;
            end
          end
        end
      end
      CHK: begin
        if (accept) begin
          state_d = (rx_data == xor_q) ? DONE : ERR;
        end
      end
      default: ;
    endcase

    rx_ready_d = (state_d == HDR0) || (state_d == HDR1) ||
                 (state_d == DATA) || (state_d == CHK);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HDR0;
      rx_ready_q     <= 1'b0;
      n_q            <= '0;
      xor_q          <= '0;
      byte_cnt_q     <= '0;
      asm_q          <= '0;
      word_idx_q     <= '0;
      imem_wen_q     <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      rx_ready_q     <= rx_ready_d;
      n_q            <= n_d;
      xor_q          <= xor_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      word_idx_q     <= word_idx_d;
      imem_wen_q     <= imem_wen_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_wen     = imem_wen_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign words_loaded = words_loaded_q;
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);
  assign cpu_rst      = (state_q != DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good, bad-checksum, oversize, empty,
// stalled and aborted frames.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_wen     (imem_wen),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  frame[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] wr_wl[$];
  int unsigned late_wr  = 0;
  int unsigned acc_cnt  = 0;
  bit          prev_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Log every write away from the clock edge; a write must follow an accepted byte
  always @(negedge clk) begin
    if (imem_wen) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_wl.push_back(32'(words_loaded));
      if (!prev_acc) late_wr++;
    end
    prev_acc = rx_valid && rx_ready;
    if (rx_valid && rx_ready) acc_cnt++;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_wl.delete();
    late_wr = 0;
    acc_cnt = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk); #1;
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_wen",   32'(imem_wen), 32'd0);
    check("rst_addr",  32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu",   32'(cpu_rst), 32'd1);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_wl",    32'(words_loaded), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_rise", 32'(rx_ready), 32'd1);
  endtask

  // Offer one byte and hold it until accepted; leaves rx_valid high
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int unsigned k;
    k = 0;
    if (stall) begin
      while ($urandom_range(1, 0) == 1 && k < 6) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
        k++;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (!rx_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rx_ready) check("send_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int unsigned count, input bit stall);
    for (int i = 0; i < int'(count); i++) send_byte(frame[i], stall);
    rx_valid = 1'b0;
  endtask

  task automatic load_good_image();
    frame.delete();
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h40, 8'h20};
  endtask

  function automatic logic [7:0] xsum();
    logic [7:0] x;
    x = 8'h00;
    foreach (frame[i]) x ^= frame[i];
    return x;
  endfunction

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_data.size(), 32'd2);
    if (wr_data.size() >= 2) begin
      check({tag, "_a0"},  wr_addr[0], 32'd0);
      check({tag, "_d0"},  wr_data[0], 32'h20080005);
      check({tag, "_wl0"}, wr_wl[0],   32'd1);
      check({tag, "_a1"},  wr_addr[1], 32'd1);
      check({tag, "_d1"},  wr_data[1], 32'h01094020);
      check({tag, "_wl1"}, wr_wl[1],   32'd2);
    end
    check({tag, "_late"}, late_wr, 32'd0);
  endtask

  task automatic check_good(input string tag);
    check_writes(tag);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_cpu"},   32'(cpu_rst), 32'd0);
    check({tag, "_rdy"},   32'(rx_ready), 32'd0);
    check({tag, "_wl"},    32'(words_loaded), 32'd2);
    check({tag, "_wen"},   32'(imem_wen), 32'd0);
    check({tag, "_hadr"},  32'(imem_addr), 32'd1);
    check({tag, "_hdat"},  imem_wdata, 32'h01094020);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Good two-word image; its checksum is 0x47
    do_reset();
    clear_log();
    load_good_image();
    frame.push_back(xsum());
    check("good_csum", 32'(frame[10]), 32'h47);
    send_frame(11, 1'b0);
    check_good("good");

    // Bad checksum: words still land, load is rejected
    do_reset();
    clear_log();
    load_good_image();
    frame.push_back(8'h44);
    send_frame(11, 1'b0);
    check_writes("bad");
    check("bad_err",  32'(err), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_cpu",  32'(cpu_rst), 32'd1);
    check("bad_rdy",  32'(rx_ready), 32'd0);
    acc_cnt  = 0;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("bad_extra_acc", acc_cnt, 32'd0);
    check("bad_extra_err", 32'(err), 32'd1);
    check("bad_extra_wl",  32'(words_loaded), 32'd2);

    // Oversize header 0xFFFF
    do_reset();
    clear_log();
    frame = '{8'hFF, 8'hFF};
    send_frame(2, 1'b0);
    check("ffff_err", 32'(err), 32'd1);
    check("ffff_rdy", 32'(rx_ready), 32'd0);
    check("ffff_cpu", 32'(cpu_rst), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("ffff_nwr", wr_data.size(), 32'd0);

    // One past capacity is rejected, exactly capacity is accepted
    do_reset();
    frame = '{8'h04, 8'h01};
    send_frame(2, 1'b0);
    check("n1025_err", 32'(err), 32'd1);
    do_reset();
    frame = '{8'h04, 8'h00};
    send_frame(2, 1'b0);
    check("n1024_err", 32'(err), 32'd0);
    check("n1024_rdy", 32'(rx_ready), 32'd1);

    // Empty image
    do_reset();
    clear_log();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(3, 1'b0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_cpu",  32'(cpu_rst), 32'd0);
    check("empty_wl",   32'(words_loaded), 32'd0);
    check("empty_nwr",  wr_data.size(), 32'd0);

    // Good image with random stalls
    do_reset();
    clear_log();
    load_good_image();
    frame.push_back(xsum());
    send_frame(11, 1'b1);
    check_good("stall");

    // Abort after six bytes: the first word completed and was written
    do_reset();
    clear_log();
    load_good_image();
    send_frame(6, 1'b0);
    do_reset();
    check("abort_nwr", wr_data.size(), 32'd1);
    if (wr_data.size() >= 1) check("abort_d0", wr_data[0], 32'h20080005);
    clear_log();
    load_good_image();
    frame.push_back(xsum());
    send_frame(11, 1'b0);
    check_good("reload");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
